// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
// The decode stage imports this same package so both ends agree on opcodes.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_SLTE_U = 4'd4;
    localparam logic [3:0] OP_SLT_U  = 4'd5;
    localparam logic [3:0] OP_SLL    = 4'd6;
    localparam logic [3:0] OP_SRL    = 4'd7;
    localparam logic [3:0] OP_XOR    = 4'd8;
    localparam logic [3:0] OP_SRA    = 4'd9;
    localparam logic [3:0] OP_SLT_S  = 4'd10;
    localparam logic [3:0] OP_SLTE_S = 4'd11;
    localparam logic [3:0] OP_MUL    = 4'd12;
    localparam logic [3:0] OP_MULHU  = 4'd13;

    typedef enum logic {
        S_IDLE,
        S_MULT
    } state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative radix-2 shift-add unsigned multiplier producing a 2*WIDTH product.
// The first partial step runs on the start edge, so done rises WIDTH-1 cycles later.
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [SHW:0]       cnt_reg;
    logic               busy_reg;

    // Upper half accumulates the multiplicand when the multiplier LSB is set,
    // then the whole register shifts right, consuming one multiplier bit.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] acc;
        acc = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {acc, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            prod_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (start && !busy_reg) begin
            mcand_reg <= a;
            prod_reg  <= step({{WIDTH{1'b0}}, b}, a);
            cnt_reg   <= {{SHW{1'b0}}, 1'b1};
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            if (cnt_reg == CNT_LAST) begin
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
            end else begin
                prod_reg <= step(prod_reg, mcand_reg);
                cnt_reg  <= cnt_reg + 1'b1;
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (cnt_reg == CNT_LAST);
    assign product = prod_reg;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops go straight to the output register,
// multiplies are handed to mul_iter and the FSM waits in S_MULT for completion.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    state_t state_reg, state_next;

    logic               out_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg, carry_reg, overflow_reg;
    logic               mul_high_reg;

    logic               accept, is_mul, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf;
    logic               load_alu, load_mul, load_res;
    logic [WIDTH-1:0]   load_val;

    assign in_ready  = (state_reg == S_IDLE) && !mul_busy && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = is_mul_op(alu_ctrl);
    assign mul_start = accept && is_mul;

    mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign sum_w  = {1'b0, op1} + {1'b0, op2};
    assign diff_w = {1'b0, op1} - {1'b0, op2};
    assign shamt  = op2[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
                alu_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_w[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the unsigned borrow.
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = diff_w[WIDTH];
                alu_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_w[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:    alu_res = op1 & op2;
            OP_OR:     alu_res = op1 | op2;
            OP_XOR:    alu_res = op1 ^ op2;
            OP_SLTE_U: alu_res = {{(WIDTH-1){1'b0}}, (op1 <= op2)};
            OP_SLT_U:  alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_SLT_S:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTE_S: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) <= $signed(op2))};
            OP_SLL:    alu_res = op1 << shamt;
            OP_SRL:    alu_res = op1 >> shamt;
            OP_SRA:    alu_res = $signed(op1) >>> shamt;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (mul_start) state_next = S_MULT;
            S_MULT:  if (mul_done)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            mul_high_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mul_start) begin
                mul_high_reg <= (alu_ctrl == OP_MULHU);
            end
        end
    end

    assign load_alu = accept && !is_mul;
    assign load_mul = (state_reg == S_MULT) && mul_done;
    assign load_res = load_alu || load_mul;
    assign load_val = load_mul ? (mul_high_reg ? mul_product[2*WIDTH-1:WIDTH]
                                               : mul_product[WIDTH-1:0])
                               : alu_res;

    // A load on the drain edge wins, so out_valid stays high across back-to-back results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (load_res) begin
            out_valid_reg <= 1'b1;
            result_reg    <= load_val;
            zero_reg      <= (load_val == '0);
            carry_reg     <= load_alu && alu_carry;
            overflow_reg  <= load_alu && alu_ovf;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;

endmodule
